// File: rtl/data_bridge_1xn_pkg.sv
// Shared types and helpers for the 1-to-N data-side bridge.
// Holds the FSM encoding and the slave-select width helper.
package bridge_pkg;

   typedef enum logic [1:0] {
      BR_IDLE = 2'd0,
      BR_REQ  = 2'd1,
      BR_WAIT = 2'd2,
      BR_RESP = 2'd3
   } state_e;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   // Select index width; a single slave still needs one bit.
   function automatic int sel_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int SEL_W_MAX = sel_w(8);

endpackage

// File: rtl/data_bridge_1xn_if.sv
// Handshake bundle between CPU data port, bridge and slaves.
// master: bridge view (drives cpu_req_ready/cpu_rsp_*, slv_req_valid/slv_we/
// slv_addr/slv_wdata). slave: environment view (CPU requests, slave replies).
interface data_bridge_1xn_if
   import bridge_pkg::*;
#(
   parameter int NUM_SLV = 2,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64
);
   logic                      cpu_req_valid;
   logic                      cpu_req_ready;
   logic [DATA_W/8-1:0]       cpu_we;
   logic [ADDR_W-1:0]         cpu_addr;
   logic [DATA_W-1:0]         cpu_wdata;
   logic                      cpu_rsp_valid;
   logic                      cpu_rsp_err;
   logic [DATA_W-1:0]         cpu_rdata;
   logic [NUM_SLV-1:0]        slv_req_valid;
   logic [NUM_SLV-1:0]        slv_req_ready;
   logic [DATA_W/8-1:0]       slv_we;
   logic [ADDR_W-1:0]         slv_addr;
   logic [DATA_W-1:0]         slv_wdata;
   logic [NUM_SLV-1:0]        slv_rsp_valid;
   logic [NUM_SLV*DATA_W-1:0] slv_rdata;

   modport master (
      input  cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
      input  slv_req_ready, slv_rsp_valid, slv_rdata,
      output cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, cpu_rdata,
      output slv_req_valid, slv_we, slv_addr, slv_wdata
   );

   modport slave (
      output cpu_req_valid, cpu_we, cpu_addr, cpu_wdata,
      output slv_req_ready, slv_rsp_valid, slv_rdata,
      input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, cpu_rdata,
      input  slv_req_valid, slv_we, slv_addr, slv_wdata
   );

endinterface

// File: rtl/data_bridge_1xn_addr_dec.sv
// Priority address decoder: lowest-index window with (addr & mask) == base wins.
// Ports: addr in; hit (any window matched) and sel (winning index) out.
module bridge_addr_dec
   import bridge_pkg::*;
#(
   parameter int NUM_SLV = 2,
   parameter int ADDR_W  = 64,
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0,
   localparam int SEL_W = sel_w(NUM_SLV)
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              hit,
   output logic [SEL_W-1:0]  sel
);

   // Scan from the top so the lowest matching index is written last.
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
             SLV_BASE[i*ADDR_W +: ADDR_W]) begin
            hit = 1'b1;
            sel = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/data_bridge_1xn.sv
// 1-to-N data bridge: one CPU request at a time, routed to a decoded slave.
// Ports: clk, rst (sync, active-high), bus (master modport of the bridge if).
// Optional abort counter enabled by defining BRIDGE_TIMEOUT_EN.
module data_bridge_1xn
   import bridge_pkg::*;
#(
   parameter int NUM_SLV = 2,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   data_bridge_1xn_if.master bus
);

   localparam int SEL_W = sel_w(NUM_SLV);
   localparam int BE_W  = DATA_W / 8;

   logic [1:0]        state;
   logic [SEL_W-1:0]  sel_q;
   logic [BE_W-1:0]   we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   logic              dec_hit;
   logic [SEL_W-1:0]  dec_sel;
   logic              to_hit;
   logic              busy;

   logic [DATA_W-1:0] rd_arr [NUM_SLV];

   for (genvar g = 0; g < NUM_SLV; g++) begin : g_rd
      assign rd_arr[g] = bus.slv_rdata[g*DATA_W +: DATA_W];
   end

   bridge_addr_dec #(
      .NUM_SLV  (NUM_SLV),
      .ADDR_W   (ADDR_W),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_dec (
      .addr (bus.cpu_addr),
      .hit  (dec_hit),
      .sel  (dec_sel)
   );

   assign busy = (state == S_REQ) || (state == S_WAIT);

`ifdef BRIDGE_TIMEOUT_EN
   logic [31:0] to_cnt;

   // Held at zero while idle, so every REQ entry starts from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (busy) begin
         to_cnt <= to_cnt + 32'd1;
      end else begin
         to_cnt <= '0;
      end
   end

   assign to_hit = busy && (to_cnt == 32'(TIMEOUT_CYC - 1));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         sel_q   <= '0;
         we_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.cpu_req_valid) begin
                  we_q    <= bus.cpu_we;
                  addr_q  <= bus.cpu_addr;
                  wdata_q <= bus.cpu_wdata;
                  rdata_q <= '0;
                  sel_q   <= dec_sel;
                  err_q   <= !dec_hit;
                  state   <= dec_hit ? S_REQ : S_RESP;
               end
            end
            S_REQ: begin
               if (to_hit) begin
                  err_q <= 1'b1;
                  state <= S_RESP;
               end else if (bus.slv_req_ready[sel_q]) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (to_hit) begin
                  err_q <= 1'b1;
                  state <= S_RESP;
               end else if (bus.slv_rsp_valid[sel_q]) begin
                  // Writes return a zero ack word, not the slave bus.
                  rdata_q <= (we_q == '0) ? rd_arr[sel_q] : '0;
                  state   <= S_RESP;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Ready is masked by rst so it reads 0 for the whole reset pulse.
   assign bus.cpu_req_ready = (state == S_IDLE) && !rst;
   assign bus.cpu_rsp_valid = (state == S_RESP);
   assign bus.cpu_rsp_err   = (state == S_RESP) && err_q;
   assign bus.cpu_rdata     = (state == S_RESP) ? rdata_q : '0;

   assign bus.slv_req_valid = (state == S_REQ) ?
                              (NUM_SLV'(1) << sel_q) : '0;
   assign bus.slv_we        = we_q;
   assign bus.slv_addr      = addr_q;
   assign bus.slv_wdata     = wdata_q;

endmodule

// File: tb/tb_data_bridge_1xn.sv
// Scoreboard bench for data_bridge_1xn with two behavioural slaves.
// Directed cases first, then randomized traffic.
module tb_data_bridge_1xn;

   localparam int NS = 2;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int TO = 8;
   localparam logic [NS*AW-1:0] BASE = {64'h8000_0000, 64'h8000_0000};
   localparam logic [NS*AW-1:0] MASK = {64'hC000_0000, 64'hF000_0000};

   logic clk;
   logic rst;

   data_bridge_1xn_if #(.NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

   data_bridge_1xn #(
      .NUM_SLV     (NS),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .SLV_BASE    (BASE),
      .SLV_MASK    (MASK),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [63:0] rdata;
   } exp_t;

   exp_t sbq[$];

   int checks;
   int errors;

   int          exp_sel;
   logic [63:0] exp_addr;
   logic [7:0]  exp_we;
   logic [63:0] exp_wdata;
   bit          saw_req;

   int force_stall;
   int force_delay;
   bit spur_en;
   bit force_spur [NS];
   bit no_rsp [NS];

   // Windows: slave 0 = 0x8xxx_xxxx, slave 1 = 0x8..0xB (bits 31:30 = 10).
   function automatic int model_sel(input logic [63:0] a);
      if (a[31:28] == 4'h8) return 0;
      if (a[31:30] == 2'b10) return 1;
      return -1;
   endfunction

   // Content the slaves hold; both the slaves and the model use it.
   function automatic logic [63:0] slave_data(input int i,
                                              input logic [63:0] a);
      if (i == 0 && a == 64'h8000_0010) return 64'h1122_3344_5566_7788;
      return {a[31:0] ^ 32'h5A5A_0000, 32'(i + 1) * 32'h0101_0101};
   endfunction

   // Slave models: optional stall, response after delay >= 1 cycle.
   int ph [NS];
   int wl [NS];
   int rl [NS];

   always @(negedge clk) begin
      bus.slv_req_ready = '0;
      bus.slv_rsp_valid = '0;
      bus.slv_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (rst) begin
         for (int i = 0; i < NS; i++) ph[i] = 0;
      end else begin
         for (int i = 0; i < NS; i++) begin
            if (ph[i] == 0 && bus.slv_req_valid[i]) begin
               wl[i] = (force_stall >= 0) ? force_stall
                                          : int'($urandom_range(0, 3));
               ph[i] = 1;
            end
            if (ph[i] == 1) begin
               if (wl[i] == 0) begin
                  bus.slv_req_ready[i] = 1'b1;
                  rl[i] = (force_delay >= 0) ? force_delay
                                             : int'($urandom_range(1, 3));
                  ph[i] = no_rsp[i] ? 0 : 2;
               end else begin
                  wl[i] = wl[i] - 1;
               end
            end else if (ph[i] == 2) begin
               rl[i] = rl[i] - 1;
               if (rl[i] == 0) begin
                  bus.slv_rsp_valid[i] = 1'b1;
                  bus.slv_rdata[i*DW +: DW] = slave_data(i, bus.slv_addr);
                  ph[i] = 0;
               end
            end else if (!bus.slv_req_valid[i] &&
                         (force_spur[i] ||
                          (spur_en && $urandom_range(0, 5) == 0))) begin
               bus.slv_rsp_valid[i] = 1'b1;
            end
         end
      end
   end

   // Monitor: slave-side request checks and scoreboard pops.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.slv_req_valid != '0) begin
            saw_req = 1'b1;
            checks++;
            if (bus.slv_req_valid != (2'b01 << exp_sel) ||
                bus.slv_addr != exp_addr || bus.slv_we != exp_we ||
                bus.slv_wdata != exp_wdata) begin
               errors++;
               $display("FAIL slv_req: valid=%b addr=%h we=%h wd=%h, expected sel=%0d addr=%h we=%h wd=%h",
                        bus.slv_req_valid, bus.slv_addr, bus.slv_we,
                        bus.slv_wdata, exp_sel, exp_addr, exp_we, exp_wdata);
            end
         end
         if (bus.cpu_rsp_valid) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: got err=%b rdata=%h, expected no response",
                        bus.cpu_rsp_err, bus.cpu_rdata);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               if (bus.cpu_rsp_err !== e.err || bus.cpu_rdata !== e.rdata) begin
                  errors++;
                  $display("FAIL rsp_data: got err=%b rdata=%h, expected err=%b rdata=%h",
                           bus.cpu_rsp_err, bus.cpu_rdata, e.err, e.rdata);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   task automatic do_txn(input logic [63:0] a, input logic [7:0] we,
                         input logic [63:0] wd, input int exp_lat,
                         input bit exp_to);
      int   s;
      int   lat;
      bit   got;
      exp_t e;
      for (int k = 0; k < 50 && !bus.cpu_req_ready; k++) @(negedge clk);
      if (!bus.cpu_req_ready) begin
         chk("req_ready_wait", 64'(bus.cpu_req_ready), 64'd1);
         return;
      end
      s = model_sel(a);
      e.err = exp_to || (s < 0);
      e.rdata = (e.err || we != 8'h00) ? 64'h0 : slave_data(s, a);
      sbq.push_back(e);
      exp_sel = s;
      exp_addr = a;
      exp_we = we;
      exp_wdata = wd;
      saw_req = 1'b0;
      bus.cpu_req_valid = 1'b1;
      bus.cpu_addr = a;
      bus.cpu_we = we;
      bus.cpu_wdata = wd;
      @(negedge clk);
      bus.cpu_req_valid = 1'b0;
      bus.cpu_addr = {$urandom, $urandom};
      bus.cpu_we = 8'($urandom);
      bus.cpu_wdata = {$urandom, $urandom};
      got = 1'b0;
      lat = 1;
      while (!got && lat <= 60) begin
         if (bus.cpu_rsp_valid) got = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      if (!got) begin
         chk("rsp_timeout", 64'd0, 64'd1);
         return;
      end
      if (exp_lat >= 0) chk("latency", 64'(lat), 64'(exp_lat));
      chk("slv_req_seen", 64'(saw_req), 64'(s >= 0));
      @(negedge clk);
      chk("ready_after_resp", 64'(bus.cpu_req_ready), 64'd1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_sel = -1;
      exp_addr = '0;
      exp_we = '0;
      exp_wdata = '0;
      saw_req = 1'b0;
      force_stall = 0;
      force_delay = 1;
      spur_en = 1'b0;
      for (int i = 0; i < NS; i++) begin
         force_spur[i] = 1'b0;
         no_rsp[i] = 1'b0;
         ph[i] = 0;
      end
      bus.cpu_req_valid = 1'b0;
      bus.cpu_we = '0;
      bus.cpu_addr = '0;
      bus.cpu_wdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          64'({bus.cpu_req_ready, bus.cpu_rsp_valid, bus.cpu_rsp_err,
               bus.slv_req_valid} != '0 || bus.cpu_rdata != '0 ||
              bus.slv_we != '0 || bus.slv_addr != '0 ||
              bus.slv_wdata != '0), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 64'(bus.cpu_req_ready), 64'd1);

      do_txn(64'h8000_0010, 8'h00, 64'h0, 3, 1'b0);
      force_stall = 4;
      do_txn(64'h9000_0040, 8'hFF, 64'hCAFE_F00D_1234_5678, 7, 1'b0);
      force_stall = 0;
      do_txn(64'h0000_0000, 8'h00, 64'h0, 1, 1'b0);
      do_txn(64'h4000_0008, 8'h0F, 64'h55, 1, 1'b0);
      force_spur[1] = 1'b1;
      force_delay = 3;
      do_txn(64'h8800_0008, 8'h00, 64'h0, 5, 1'b0);
      force_spur[1] = 1'b0;
      force_delay = 1;
      do_txn(64'hB000_0100, 8'h00, 64'h0, 3, 1'b0);

`ifdef BRIDGE_TIMEOUT_EN
      no_rsp[0] = 1'b1;
      do_txn(64'h8000_0200, 8'h00, 64'h0, TO + 1, 1'b1);
      no_rsp[0] = 1'b0;
      do_txn(64'h8000_0210, 8'h00, 64'h0, 3, 1'b0);
`endif

      // Reset while the bridge waits on a slow slave response.
      force_delay = 8;
      for (int k = 0; k < 50 && !bus.cpu_req_ready; k++) @(negedge clk);
      exp_sel = 0;
      exp_addr = 64'h8000_0100;
      exp_we = 8'h00;
      exp_wdata = 64'h0;
      bus.cpu_req_valid = 1'b1;
      bus.cpu_addr = 64'h8000_0100;
      bus.cpu_we = 8'h00;
      bus.cpu_wdata = 64'h0;
      @(negedge clk);
      bus.cpu_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_in_wait",
          64'({bus.cpu_req_ready, bus.cpu_rsp_valid, bus.cpu_rsp_err,
               bus.slv_req_valid} != '0 || bus.cpu_rdata != '0 ||
              bus.slv_we != '0 || bus.slv_addr != '0 ||
              bus.slv_wdata != '0), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      force_delay = 1;
      @(negedge clk);
      chk("ready_after_reset2", 64'(bus.cpu_req_ready), 64'd1);
      do_txn(64'h8000_0010, 8'h00, 64'h0, 3, 1'b0);

      force_stall = -1;
      force_delay = -1;
      spur_en = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [63:0] a;
         logic [7:0]  we;
         logic [31:0] lo;
         lo = $urandom;
         case ($urandom_range(0, 4))
            0: lo = {4'h8, lo[27:0]};
            1: lo = {4'h9, lo[27:0]};
            2: lo = {4'hB, lo[27:0]};
            3: lo = {4'h0, lo[27:0]};
            default: lo = {4'h4, lo[27:0]};
         endcase
         a = {$urandom, lo};
         we = ($urandom_range(0, 1) == 0) ? 8'h00
                                          : 8'($urandom_range(1, 255));
         do_txn(a, we, {$urandom, $urandom}, -1, 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
